// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - gated edge counter that qualifies a monitored clock
// Counts synchronized toggle edges per gate window and debounces the result into clock_ok.
module clk_freq_monitor #(
    parameter int GATE_CYCLES = 4096,
    parameter int EXP_COUNT   = 512,
    parameter int TOLERANCE   = 4,
    parameter int OK_WINDOWS  = 4,
    parameter int LOSS_CYCLES = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mon_toggle,
    output logic [CNT_WIDTH-1:0] freq_count,
    output logic                 freq_valid,
    output logic                 in_range,
    output logic                 clock_ok,
    output logic                 clock_lost,
    output logic [1:0]           state,
    output logic [7:0]           fail_count
);

    localparam int GW  = $clog2(GATE_CYCLES);
    localparam int IW  = $clog2(LOSS_CYCLES + 1);
    localparam int KW  = $clog2(OK_WINDOWS + 1);
    localparam int CW1 = CNT_WIDTH + 1;

    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [IW-1:0]        LOSS_C    = IW'(LOSS_CYCLES);
    localparam logic [KW-1:0]        OK_C      = KW'(OK_WINDOWS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CW1-1:0]       EXP_C     = CW1'(EXP_COUNT);
    localparam logic [CW1-1:0]       TOL_C     = CW1'(TOLERANCE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OK    = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    logic                 s1_q, s2_q, s3_q;
    logic [GW-1:0]        gate_q, gate_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [IW-1:0]        idle_q, idle_d;
    logic [KW-1:0]        good_q, good_d;
    state_t               state_q, state_d;
    logic [7:0]           fail_count_q, fail_count_d;
    logic [CNT_WIDTH-1:0] freq_count_q, freq_count_d;
    logic                 freq_valid_q, freq_valid_d;
    logic                 in_range_q, in_range_d;
    logic                 clock_ok_q, clock_ok_d;
    logic                 clock_lost_q, clock_lost_d;

    logic                 edge_det;
    logic                 win_close;
    logic [CNT_WIDTH-1:0] edge_sum;
    logic [CW1-1:0]       count_ext;
    logic [CW1-1:0]       diff;
    logic [KW-1:0]        good_inc;
    logic [7:0]           fail_sat;

    // Datapath: window counting, result publication and loss detection
    always_comb begin
        edge_det     = s2_q ^ s3_q;
        win_close    = (gate_q == GATE_LAST);
        gate_d       = win_close ? '0 : gate_q + GW'(1);
        edge_sum     = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_WIDTH'(edge_det);
        edge_cnt_d   = win_close ? '0 : edge_sum;
        count_ext    = {1'b0, edge_sum};
        diff         = (count_ext >= EXP_C) ? count_ext - EXP_C : EXP_C - count_ext;
        freq_count_d = win_close ? edge_sum : freq_count_q;
        in_range_d   = win_close ? (diff <= TOL_C) : in_range_q;
        freq_valid_d = win_close;
        if (edge_det) begin
            idle_d = '0;
        end else if (idle_q == LOSS_C) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IW'(1);
        end
        clock_lost_d = (idle_d == LOSS_C);
    end

    // Loss is evaluated before window results so it wins a same-cycle tie
    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        fail_count_d = fail_count_q;
        good_inc     = good_q + KW'(1);
        fail_sat     = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
        if (clock_lost_d && state_q != ST_IDLE) begin
            if (state_q == ST_OK) begin
                fail_count_d = fail_sat;
            end
            state_d = ST_FAIL;
            good_d  = '0;
        end else if (freq_valid_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
                ST_CHECK: begin
                    if (in_range_q) begin
                        good_d = good_inc;
                        if (good_inc == OK_C) begin
                            state_d = ST_OK;
                        end
                    end else begin
                        state_d = ST_FAIL;
                        good_d  = '0;
                    end
                end
                ST_OK: begin
                    if (!in_range_q) begin
                        state_d      = ST_FAIL;
                        fail_count_d = fail_sat;
                    end
                end
                ST_FAIL: begin
                    if (in_range_q) begin
                        state_d = ST_CHECK;
                        good_d  = KW'(1);
                    end
                end
            endcase
        end
        clock_ok_d = (state_d == ST_OK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            gate_q       <= '0;
            edge_cnt_q   <= '0;
            idle_q       <= '0;
            good_q       <= '0;
            state_q      <= ST_IDLE;
            fail_count_q <= '0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            in_range_q   <= 1'b0;
            clock_ok_q   <= 1'b0;
            clock_lost_q <= 1'b0;
        end else begin
            s1_q         <= mon_toggle;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            gate_q       <= gate_d;
            edge_cnt_q   <= edge_cnt_d;
            idle_q       <= idle_d;
            good_q       <= good_d;
            state_q      <= state_d;
            fail_count_q <= fail_count_d;
            freq_count_q <= freq_count_d;
            freq_valid_q <= freq_valid_d;
            in_range_q   <= in_range_d;
            clock_ok_q   <= clock_ok_d;
            clock_lost_q <= clock_lost_d;
        end
    end

    assign freq_count = freq_count_q;
    assign freq_valid = freq_valid_q;
    assign in_range   = in_range_q;
    assign clock_ok   = clock_ok_q;
    assign clock_lost = clock_lost_q;
    assign state      = state_q;
    assign fail_count = fail_count_q;

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Verifies the frequency of a DCM-generated clock by measuring it in the system clock domain.
- The monitored domain drives a toggle flop (mon_toggle) that flips on every monitored-clock cycle.
- This block synchronizes that toggle, counts its edges over a fixed gate window of clk cycles, and compares the count against an expected value.
- It publishes a debounced clock_ok, a fast loss-of-clock flag and a saturating failure counter for the register map and the reset sequencer.

Parameters:
GATE_CYCLES, 4096, clk cycles per measurement window (20.48 us at 200 MHz)
EXP_COUNT, 512, expected edges per window (25 MHz monitored clock, 200 MHz clk)
TOLERANCE, 4, allowed absolute deviation from EXP_COUNT, inclusive
OK_WINDOWS, 4, consecutive in-range windows required to assert clock_ok
LOSS_CYCLES, 64, clk cycles without an edge that declare the clock lost
CNT_WIDTH, 16, width of the edge counter and freq_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
mon_toggle  input  1  asynchronous toggle from the monitored domain; flips once per monitored cycle
freq_count  output  CNT_WIDTH  edge count of the last completed window
freq_valid  output  1  one-cycle pulse when freq_count and in_range update
in_range  output  1  last window within EXP_COUNT +/- TOLERANCE
clock_ok  output  1  monitored clock qualified (debounced)
clock_lost  output  1  no edge seen for LOSS_CYCLES clk cycles
state  output  2  FSM state: 0 IDLE, 1 CHECK, 2 OK, 3 FAIL
fail_count  output  8  saturating count of OK->FAIL transitions

Behaviour:
- Reset: every output 0; state=IDLE; synchronizer, gate, edge, idle and good counters cleared. A reset mid-window discards the partial count.
- Synchronizer: 3 flops s1->s2->s3. edge = s2 ^ s3. Both polarities count, so one edge equals one monitored cycle.
- Gate counter: runs 0..GATE_CYCLES-1 and wraps.
- Edge counter: increments on edge and saturates at 2^CNT_WIDTH-1 (no wrap).
- Window close (gate counter = GATE_CYCLES-1), all on the next clk edge:
  - freq_count <= saturated(edge_cnt + edge); the final-cycle edge is included.
  - edge_cnt cleared, or set to 0 when that cycle's edge is already folded in.
  - freq_valid pulses high for exactly 1 cycle.
  - in_range <= (|count - EXP_COUNT| <= TOLERANCE), computed unsigned without underflow.
- Result latency: freq_count, freq_valid and in_range appear 1 cycle after the closing cycle.
- FSM transitions are evaluated on freq_valid:
  - IDLE: the first window after reset is discarded (synchronizer warm-up) -> CHECK with good_cnt=0.
  - CHECK, in-range window: good_cnt++. When good_cnt reaches OK_WINDOWS -> OK.
  - CHECK, out-of-range window -> FAIL, good_cnt=0.
  - OK, out-of-range window -> FAIL; fail_count++ (saturates at 255).
  - FAIL, in-range window -> CHECK with good_cnt=1.
- clock_ok = (state==OK), registered. It asserts in the same cycle state becomes OK.
- Loss detect:
  - idle_cnt clears on edge and otherwise increments, saturating at LOSS_CYCLES.
  - When it reaches LOSS_CYCLES: clock_lost=1 and the FSM forces FAIL immediately, mid-window, from any state except IDLE.
  - From OK, the forced transition increments fail_count.
  - clock_lost clears on the first subsequent edge.
  - While clock_lost=1, window results are still published but the FSM stays in FAIL.
- Simultaneous loss and freq_valid in the same cycle: loss wins.
- Max measurable edge rate: 1 edge per clk cycle. A faster toggle aliases; the integration rule is monitored clock < clk/2.

Test Plan:
- Nominal: toggle flips every 8 clk cycles (25 MHz vs 200 MHz), exactly 512 edges per window. After the first freq_valid (discarded) plus 4 windows: freq_count=512, in_range=1, clock_ok=1, state=2.
- Tolerance edges: windows of exactly 508 and 516 edges -> in_range=1. Windows of 507 and 517 -> in_range=0. A single 517 window while OK -> state=3, clock_ok=0, fail_count=1.
- Wrong frequency: toggle every 9 cycles (455 edges/window) -> in_range=0 every window, clock_ok never asserts, state stays 3.
- Loss: reach OK, then freeze mon_toggle. 64 cycles after the last edge: clock_lost=1, clock_ok=0, state=3, fail_count increments. Restart toggling -> clock_lost=0 on the first edge, and clock_ok returns after 4 good windows (the first good window moves FAIL->CHECK).
- Saturation: CNT_WIDTH=10, toggle every clk cycle -> freq_count=1023 with no wrap, in_range=0.
- Reset mid-window: pulse reset at gate count 2000 while OK -> all outputs 0, state=0 the next cycle. The next freq_valid arrives 4096 cycles after reset deasserts and is discarded (state->1, clock_ok=0).
